// File: rtl/mem_slave_ws_if.sv
// Purpose: valid/ready memory bus bundle between a bus master and mem_slave_ws.
// Signals:
//   valid, wr_rd, addr, wdata, wstrb : request, driven by the master
//   ready, rdata, err, busy          : response and status, driven by the slave
interface mem_slave_ws_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic                  ready;
  logic [WIDTH-1:0]      rdata;
  logic                  err;
  logic                  busy;

  modport master (
    output valid, wr_rd, addr, wdata, wstrb,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  valid, wr_rd, addr, wdata, wstrb,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/mem_slave_ws.sv
// Purpose: single-port memory slave with configurable wait states, byte-lane
// write strobes, out-of-range error response and busy flag.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active-high (memory contents are kept)
//   bus  : mem_slave_ws_if slave modport
//          valid/wr_rd/addr/wdata/wstrb in, ready/rdata/err/busy out
//
// state | meaning
// IDLE  | waiting for valid; accepts and latches the request
// WAIT  | counting down wait states on the latched request
// RESP  | one-cycle ready pulse with rdata/err; valid ignored
module mem_slave_ws #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  mem_slave_ws_if.slave bus
);
  localparam int NLANES = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  complete;

  logic                  lat_wr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]      lat_wdata;
  logic [NLANES-1:0]     lat_wstrb;

  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic [NLANES-1:0]     req_wstrb;
  logic                  in_range;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      rdata_q;
  logic                  err_q;

  // With zero wait states the completion happens on the accept edge, so the
  // live bus is used in IDLE; afterwards only the latched copy counts.
  always_comb begin
    if (state_q == IDLE) begin
      req_wr    = bus.wr_rd;
      req_addr  = bus.addr;
      req_wdata = bus.wdata;
      req_wstrb = bus.wstrb;
    end else begin
      req_wr    = lat_wr;
      req_addr  = lat_addr;
      req_wdata = lat_wdata;
      req_wstrb = lat_wstrb;
    end
  end

  assign in_range = (32'(req_addr) < 32'(DEPTH));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          cnt_d = 8'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          complete = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= complete && !in_range;
      // In-range writes leave rdata holding the last read value.
      if (complete && (!req_wr || !in_range)) begin
        rdata_q <= in_range ? mem[req_addr] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.valid) begin
      lat_wr    <= bus.wr_rd;
      lat_addr  <= bus.addr;
      lat_wdata <= bus.wdata;
      lat_wstrb <= bus.wstrb;
    end
  end

  // Memory is never reset; a reset on the completion edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && complete && req_wr && in_range) begin
      for (int i = 0; i < NLANES; i++) begin
        if (req_wstrb[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign bus.ready = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
endmodule
